uart_rx: RTL and testbench

- Serial byte receiver that sits directly upstream of the program loader.
- Converts the asynchronous UART line (8N1, LSB first) into a one-cycle rx_ready strobe with a parallel rx_data byte.
- The loader samples rx_ready/rx_data every clk cycle with no back-pressure, so this block never stalls and never buffers more than one byte.
- Also flags framing errors for LED/debug use.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver. It emits a one-cycle rx_ready strobe
// with a parallel byte, or a one-cycle frame_err strobe when the stop bit is
// sampled low. It has no back-pressure and holds at most one byte.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             sync1_q, rx_s_q;

    // Two-flop synchroniser. The flops reset high so the line reads as idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rx_s_q  <= sync1_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic. Bits are sampled at mid-bit: the start bit is
    // qualified half a bit in, and each later sample is one full bit after
    // the previous one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            // A line held low (break, or reset mid-frame) must go high
            // before any falling edge is treated as a start bit.
            WAIT_IDLE: begin
                if (rx_s_q) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;   // glitch: drop it with no strobe
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    cnt_d   = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_data_d  = shreg_q;
                        rx_ready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign rx_ready  = rx_ready_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives whole 8N1 frames onto rxd and compares each strobe
// against a frame-level expectation list. Each expectation holds the strobe
// time (start edge + N), the byte, and the error flag.
module tb_uart_rx;
    localparam int C = 8;
    localparam int N = 2 + C / 2 + 9 * C;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       err;
        logic       bsy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready, frame_err, busy;
    logic [7:0] rx_data;

    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         both_hi = 0;
    int         data_glitch = 0;
    logic       mon_en = 1'b0;
    logic       rst_seen = 1'b1;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] last_good = 8'h00;
    ev_t        exp_q[$];
    ev_t        got_q[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_seen <= rst;
    end

    // Record every strobe, and note rx_data changes that arrive without one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_ready || frame_err) got_q.push_back('{cyc, rx_data, frame_err, busy});
            if (rx_ready && frame_err) both_hi++;
            if (!rst_seen && !rx_ready && rx_data !== prev_data) data_glitch++;
            prev_data = rx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns on a negedge; the next frame can follow with no gap.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t e;
        e.t   = cyc + 1 + N;
        e.err = !stop;
        e.bsy = 1'b0;
        if (stop) last_good = b;
        e.d = last_good;
        exp_q.push_back(e);
        rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk);
        end
        rxd = stop;
        repeat (C) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_events(input string tag);
        ev_t e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_present"}, got_q.size(), (got_q.size() > 0) ? got_q.size() : 1);
            if (got_q.size() == 0) break;
            g = got_q.pop_front();
            chk({tag, "_time"}, g.t, e.t);
            chk({tag, "_data"}, g.d, e.d);
            chk({tag, "_err"}, g.err, e.err);
            chk({tag, "_busy"}, g.bsy, e.bsy);
        end
        exp_q.delete();
        chk({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
        chk({tag, "_rx_data"}, rx_data, last_good);
    endtask

    initial begin
        logic [7:0] b;

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_ready", rx_ready, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle line: all outputs quiet.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_ready", rx_ready, 1'b0);
            chk("idle_ferr", frame_err, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_data", rx_data, 8'h00);
        end

        // A single clean frame.
        send_frame(8'hA5, 1'b1);
        idle(10);
        check_events("a5");

        // Three back-to-back frames, 10*C apart.
        send_frame(8'h00, 1'b1);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(10);
        check_events("b2b");

        // Two-cycle low glitch is rejected, then a real frame follows.
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check_events("glitch");
        send_frame(8'h3C, 1'b1);
        idle(10);
        check_events("after_glitch");

        // Stop bit low, then line held low: one frame_err, and no start is
        // taken until the line returns high.
        send_frame(8'h5A, 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        chk("ferr_hold_busy", busy, 1'b0);
        check_events("ferr");
        idle(10);
        send_frame(8'hC3, 1'b1);
        idle(10);
        check_events("after_ferr");

        // Reset during data bit 4: the partial byte is dropped and rx_data is
        // cleared. The rest of the frame keeps the line high.
        b = 8'hF0;
        rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk);
        end
        rxd = b[4];
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (C - 4) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk);
        end
        idle(C + 30);
        check_events("rst_mid");
        send_frame(8'h7E, 1'b1);
        idle(10);
        check_events("after_rst");

        // Random bytes with random idle gaps, including zero.
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom_range(255)), 1'b1);
            idle($urandom_range(15));
        end
        idle(10);
        check_events("random");

        chk("no_dual_strobe", both_hi, 0);
        chk("rx_data_stable", data_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
